// File: rtl/tx_code_group_pkg.sv
// tx_code_group_pkg: shared constants for the 1000BASE-X transmit code-group path.
// Holds the one-hot ordered-set request codes, the 8b/10b code points used by
// the generator, the generator FSM state encoding and a request sanitiser.
package tx_code_group_pkg;

  // One-hot ordered-set requests from the ordered-set state machine
  localparam logic [4:0] OSET_R = 5'b00001;
  localparam logic [4:0] OSET_S = 5'b00010;
  localparam logic [4:0] OSET_T = 5'b00100;
  localparam logic [4:0] OSET_D = 5'b01000;
  localparam logic [4:0] OSET_I = 5'b10000;

  // Code-group octets
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D5_6  = 8'hC5;

  // Generator states; each state names the code group it emits
  typedef enum logic [2:0] {
    ST_IDLE_K,
    ST_IDLE_D,
    ST_SOP,
    ST_DATA,
    ST_EOP_T,
    ST_EOP_R,
    ST_EOP_R2
  } cg_state_e;

  // Anything that is not exactly one-hot is an idle request
  function automatic logic [4:0] oset_sanitize(input logic [4:0] oset);
    return $onehot(oset) ? oset : OSET_I;
  endfunction

endpackage

// File: rtl/tx_code_group_if.sv
// tx_code_group_if: request/data bus from the ordered-set state machine and
// the code-group bus towards the 8b/10b encoder.
// With TX_CG_RD_EN defined the bus also carries the running disparity tx_rd.
interface tx_code_group_if;

  logic [4:0] tx_o_set;
  logic [7:0] TXD;
  logic [7:0] tx_code_group;
  logic       tx_is_k;
  logic       tx_even;
`ifdef TX_CG_RD_EN
  logic       tx_rd;

  modport master (
    output tx_o_set, TXD,
    input  tx_code_group, tx_is_k, tx_even, tx_rd
  );

  modport slave (
    input  tx_o_set, TXD,
    output tx_code_group, tx_is_k, tx_even, tx_rd
  );
`else
  modport master (
    output tx_o_set, TXD,
    input  tx_code_group, tx_is_k, tx_even
  );

  modport slave (
    input  tx_o_set, TXD,
    output tx_code_group, tx_is_k, tx_even
  );
`endif

endinterface

// File: rtl/tx_code_group_cg_disparity.sv
// cg_disparity: tells whether an 8b/10b code group changes running disparity.
// Only built with TX_CG_RD_EN. A group flips RD when exactly one of its two
// sub-blocks (5b/6b over bits 4:0, 3b/4b over bits 7:5) is disparity-unbalanced.
`ifdef TX_CG_RD_EN
module cg_disparity (
  input  logic [7:0] data_i,
  input  logic       is_k_i,
  output logic       flips_rd_o
);

  logic [2:0] ones5;
  logic       unbal5;
  logic       unbal3;

  // 5b/6b: balanced for two or three ones, except D.24; K.28 is unbalanced.
  // 3b/4b: x.0, x.4 and x.7 are unbalanced for both data and control groups.
  always_comb begin
    ones5  = 3'($countones(data_i[4:0]));
    unbal5 = ((ones5 != 3'd2) && (ones5 != 3'd3))
             || (data_i[4:0] == 5'd24)
             || (is_k_i && (data_i[4:0] == 5'd28));
    unbal3 = (data_i[7:5] == 3'd0) || (data_i[7:5] == 3'd4) || (data_i[7:5] == 3'd7);
    flips_rd_o = unbal5 ^ unbal3;
  end

endmodule
`endif

// File: rtl/tx_code_group.sv
// tx_code_group: turns ordered-set requests plus GMII bytes into one code-group
// octet per clock, keeping /S/ on even slots and padding packet ends with an
// extra /R/ so the following K28.5 is even. A start request that would land on
// an odd slot pushes the whole packet through a second register stage (skid).
// Optional macro TX_CG_RD_EN adds running-disparity tracking and the tx_rd output.
module tx_code_group
  import tx_code_group_pkg::*;
#(
  parameter logic [7:0] IDLE_D_DEFAULT = D16_2
) (
  input logic            clk,
  input logic            mr_main_reset,
  tx_code_group_if.slave cg
);

  cg_state_e  state_q, state_d;
  logic       skid_q, skid_d;
  logic [4:0] reqDly_q;
  logic [7:0] txdDly_q;
  logic [4:0] reqIn;
  logic [4:0] reqEff;
  logic [7:0] txdEff;
  logic [7:0] code_q, code_d;
  logic       isK_q, isK_d;
  logic       even_q, even_d;
  logic [7:0] idleByte;

  assign reqIn = oset_sanitize(cg.tx_o_set);

`ifdef TX_CG_RD_EN
  logic rd_q, rd_d;
  logic flipsRd;

  // Positive disparity ahead of the idle data group selects D5.6
  assign idleByte = rd_q ? D5_6 : IDLE_D_DEFAULT;

  cg_disparity u_disparity (
    .data_i     (code_d),
    .is_k_i     (isK_d),
    .flips_rd_o (flipsRd)
  );

  assign rd_d = rd_q ^ flipsRd;
`else
  assign idleByte = IDLE_D_DEFAULT;
`endif

  // Second request/data stage, loaded every cycle and read only while skid is set
  always_ff @(posedge clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      reqDly_q <= OSET_I;
      txdDly_q <= 8'h00;
    end else begin
      reqDly_q <= reqIn;
      txdDly_q <= cg.TXD;
    end
  end

  // Pick the one-cycle or two-cycle request path
  always_comb begin
    reqEff = skid_q ? reqDly_q : reqIn;
    txdEff = skid_q ? txdDly_q : cg.TXD;
  end

  // Next state, skid control and the code group the next state emits
  always_comb begin
    state_d = state_q;
    skid_d  = skid_q;
    code_d  = code_q;
    isK_d   = isK_q;

    case (state_q)
      ST_IDLE_K: begin
        state_d = ST_IDLE_D;
        if (reqEff == OSET_S) skid_d = 1'b1;
      end
      ST_IDLE_D: state_d = (reqEff == OSET_S) ? ST_SOP : ST_IDLE_K;
      ST_SOP:    state_d = (reqEff == OSET_D) ? ST_DATA : ST_EOP_T;
      ST_DATA:   state_d = (reqEff == OSET_D) ? ST_DATA : ST_EOP_T;
      ST_EOP_T:  state_d = ST_EOP_R;
      ST_EOP_R:  state_d = even_q ? ST_EOP_R2 : ST_IDLE_K;
      ST_EOP_R2: state_d = ST_IDLE_K;
      default:   state_d = ST_IDLE_K;
    endcase

    if (state_d == ST_IDLE_K) skid_d = 1'b0;

    case (state_d)
      ST_IDLE_K: begin code_d = K28_5;    isK_d = 1'b1; end
      ST_IDLE_D: begin code_d = idleByte; isK_d = 1'b0; end
      ST_SOP:    begin code_d = K27_7;    isK_d = 1'b1; end
      ST_DATA:   begin code_d = txdEff;   isK_d = 1'b0; end
      ST_EOP_T:  begin code_d = K29_7;    isK_d = 1'b1; end
      default:   begin code_d = K23_7;    isK_d = 1'b1; end
    endcase

    even_d = ((state_d == ST_IDLE_K) || (state_d == ST_SOP)) ? 1'b1 : ~even_q;
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q <= ST_IDLE_K;
      skid_q  <= 1'b0;
      code_q  <= K28_5;
      isK_q   <= 1'b1;
      even_q  <= 1'b1;
`ifdef TX_CG_RD_EN
      rd_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      skid_q  <= skid_d;
      code_q  <= code_d;
      isK_q   <= isK_d;
      even_q  <= even_d;
`ifdef TX_CG_RD_EN
      rd_q    <= rd_d;
`endif
    end
  end

  assign cg.tx_code_group = code_q;
  assign cg.tx_is_k       = isK_q;
  assign cg.tx_even       = even_q;
`ifdef TX_CG_RD_EN
  assign cg.tx_rd         = rd_q;
`endif

endmodule

// File: tb/tb_tx_code_group.sv
// tb_tx_code_group: directed literal sequences followed by random packets, all
// cross-checked every cycle against a slot-queue model of the output stream.
// Honours TX_CG_RD_EN when the design is built with it.
module tb_tx_code_group;

  localparam logic [4:0] SET_R = 5'b00001;
  localparam logic [4:0] SET_S = 5'b00010;
  localparam logic [4:0] SET_T = 5'b00100;
  localparam logic [4:0] SET_D = 5'b01000;
  localparam logic [4:0] SET_I = 5'b10000;

  typedef struct packed {
    logic [7:0] code;
    logic       k;
    logic       even;
    logic       idleD;
  } slotT;

  logic clock = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clock = ~clock;

  tx_code_group_if cgIf ();

  tx_code_group dut (
    .clk           (clock),
    .mr_main_reset (reset),
    .cg            (cgIf)
  );

  // Reference model: a queue of future output slots; with nothing queued the
  // line carries the idle K28.5/idle-data alternation.
  slotT slotQ[$];
  logic tailEven = 1'b1;
  logic inPkt    = 1'b0;
  slotT expSlot;
  logic modelRd  = 1'b0;

  function automatic logic modelFlips(input logic [7:0] code, input logic k);
    logic [31:0] unbal5Mask;
    logic [7:0]  unbal3Mask;
    logic        u5;
    unbal5Mask = 32'hE981_8117;
    unbal3Mask = 8'h91;
    u5 = unbal5Mask[code[4:0]] | (k && code[4:0] == 5'd28);
    return u5 ^ unbal3Mask[code[7:5]];
  endfunction

  task automatic pushSlot(input logic [7:0] code, input logic k, input logic idleD);
    slotT s;
    s.code  = code;
    s.k     = k;
    s.even  = ~tailEven;
    s.idleD = idleD;
    tailEven = s.even;
    slotQ.push_back(s);
  endtask

  task automatic modelStep();
    logic [4:0] req;
    slotT s;
    if (reset) begin
      slotQ.delete();
      tailEven = 1'b1;
      inPkt    = 1'b0;
      modelRd  = 1'b0;
      expSlot  = '{code: 8'hBC, k: 1'b1, even: 1'b1, idleD: 1'b0};
      return;
    end
    req = cgIf.tx_o_set;
    if ($countones(req) != 1) req = SET_I;
    if (!inPkt) begin
      if (req == SET_S) begin
        if (tailEven) pushSlot(8'h50, 1'b0, 1'b1);
        pushSlot(8'hFB, 1'b1, 1'b0);
        inPkt = 1'b1;
      end
    end else begin
      case (req)
        SET_D: pushSlot(cgIf.TXD, 1'b0, 1'b0);
        SET_T: pushSlot(8'hFD, 1'b1, 1'b0);
        SET_R: begin
          pushSlot(8'hF7, 1'b1, 1'b0);
          if (tailEven) pushSlot(8'hF7, 1'b1, 1'b0);
          inPkt = 1'b0;
        end
        default: ;
      endcase
    end
    if (slotQ.size() > 0) begin
      s = slotQ.pop_front();
    end else begin
      s.even   = ~tailEven;
      tailEven = s.even;
      s.code   = s.even ? 8'hBC : 8'h50;
      s.k      = s.even;
      s.idleD  = ~s.even;
    end
`ifdef TX_CG_RD_EN
    if (s.idleD && modelRd) s.code = 8'hC5;
    modelRd = modelRd ^ modelFlips(s.code, s.k);
`endif
    expSlot = s;
  endtask

  task automatic compareVal(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  // Per-cycle comparison of the DUT against the model, just after each edge
  always @(posedge clock) begin
    modelStep();
    #2;
    compareVal("model.code", cgIf.tx_code_group, expSlot.code);
    compareVal("model.isK", {7'd0, cgIf.tx_is_k}, {7'd0, expSlot.k});
    compareVal("model.even", {7'd0, cgIf.tx_even}, {7'd0, expSlot.even});
`ifdef TX_CG_RD_EN
    compareVal("model.rd", {7'd0, cgIf.tx_rd}, {7'd0, modelRd});
`endif
  end

  task automatic applyStimulus(input logic [4:0] oset, input logic [7:0] txd);
    @(negedge clock);
    cgIf.tx_o_set = oset;
    cgIf.TXD      = txd;
  endtask

  task automatic checkNow(input string name, input logic [7:0] code, input logic k, input logic even);
    logic [7:0] want;
    want = code;
`ifdef TX_CG_RD_EN
    if (code == 8'h50 && cgIf.tx_code_group == 8'hC5) want = 8'hC5;
`endif
    compareVal({name, ".code"}, cgIf.tx_code_group, want);
    compareVal({name, ".isK"}, {7'd0, cgIf.tx_is_k}, {7'd0, k});
    compareVal({name, ".even"}, {7'd0, cgIf.tx_even}, {7'd0, even});
  endtask

  task automatic checkOutput(input string name, input logic [7:0] code, input logic k, input logic even);
    @(posedge clock);
    #3;
    checkNow(name, code, k, even);
  endtask

  task automatic step(input string name, input logic [4:0] oset, input logic [7:0] txd,
                      input logic [7:0] code, input logic k, input logic even);
    applyStimulus(oset, txd);
    checkOutput(name, code, k, even);
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    cgIf.tx_o_set = SET_I;
    @(negedge clock);
    reset = 1'b0;
  endtask

  int         gap;
  int         nBytes;
  int         abortAt;
  bit         aborted;
  logic [4:0] oset;

  initial begin
    reset = 1'b0;
    cgIf.tx_o_set = SET_I;
    cgIf.TXD      = 8'h00;
    #2 reset = 1'b1;
    #2 checkNow("resetState", 8'hBC, 1'b1, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("idle1", 8'h50, 1'b0, 1'b0);
    step("idle2", SET_I, 8'h00, 8'hBC, 1'b1, 1'b1);
    step("idle3", SET_I, 8'h00, 8'h50, 1'b0, 1'b0);
    // even-aligned packet
    step("evenS",  SET_S, 8'h00, 8'hFB, 1'b1, 1'b1);
    step("evenD1", SET_D, 8'h11, 8'h11, 1'b0, 1'b0);
    step("evenD2", SET_D, 8'h22, 8'h22, 1'b0, 1'b1);
    step("evenD3", SET_D, 8'h33, 8'h33, 1'b0, 1'b0);
    step("evenT",  SET_T, 8'h00, 8'hFD, 1'b1, 1'b1);
    step("evenR",  SET_R, 8'h00, 8'hF7, 1'b1, 1'b0);
    step("evenK",  SET_I, 8'h00, 8'hBC, 1'b1, 1'b1);
    step("evenI",  SET_I, 8'h00, 8'h50, 1'b0, 1'b0);
    // ignored requests while idle
    step("illegal", 5'b00011, 8'h00, 8'hBC, 1'b1, 1'b1);
    step("idleT",   SET_T, 8'h00, 8'h50, 1'b0, 1'b0);
    step("idleR",   SET_R, 8'h00, 8'hBC, 1'b1, 1'b1);
    // odd-aligned packet through the skid stage
    step("oddS",   SET_S, 8'h00, 8'h50, 1'b0, 1'b0);
    step("oddD1",  SET_D, 8'hAA, 8'hFB, 1'b1, 1'b1);
    step("oddD2",  SET_D, 8'hBB, 8'hAA, 1'b0, 1'b0);
    step("oddT",   SET_T, 8'h00, 8'hBB, 1'b0, 1'b1);
    step("oddR",   SET_R, 8'h00, 8'hFD, 1'b1, 1'b0);
    step("oddR1",  SET_I, 8'h00, 8'hF7, 1'b1, 1'b1);
    step("oddR2",  SET_I, 8'h00, 8'hF7, 1'b1, 1'b0);
    step("oddK",   SET_I, 8'h00, 8'hBC, 1'b1, 1'b1);
    step("oddI",   SET_I, 8'h00, 8'h50, 1'b0, 1'b0);
    // even start with two bytes needs the alignment /R/
    step("xrS",  SET_S, 8'h00, 8'hFB, 1'b1, 1'b1);
    step("xrD1", SET_D, 8'h01, 8'h01, 1'b0, 1'b0);
    step("xrD2", SET_D, 8'h02, 8'h02, 1'b0, 1'b1);
    step("xrT",  SET_T, 8'h00, 8'hFD, 1'b1, 1'b0);
    step("xrR",  SET_R, 8'h00, 8'hF7, 1'b1, 1'b1);
    step("xrR2", SET_I, 8'h00, 8'hF7, 1'b1, 1'b0);
    step("xrK",  SET_I, 8'h00, 8'hBC, 1'b1, 1'b1);
    step("xrI",  SET_I, 8'h00, 8'h50, 1'b0, 1'b0);
    // reset in the middle of a packet
    step("rstS",  SET_S, 8'h00, 8'hFB, 1'b1, 1'b1);
    step("rstD1", SET_D, 8'h5A, 8'h5A, 1'b0, 1'b0);
    @(negedge clock);
    cgIf.tx_o_set = SET_D;
    cgIf.TXD      = 8'h5B;
    reset         = 1'b1;
    #1 checkNow("midReset", 8'hBC, 1'b1, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    cgIf.tx_o_set = SET_I;
    checkOutput("postRstD", 8'h50, 1'b0, 1'b0);
    step("postRstK", SET_I, 8'h00, 8'hBC, 1'b1, 1'b1);

    $display("[TB] random packets");
    for (int p = 0; p < 40; p++) begin
      gap = $urandom_range(4, 9);
      for (int g = 0; g < gap; g++) begin
        case ($urandom_range(0, 5))
          0, 1: oset = SET_I;
          2:    oset = SET_R;
          3:    oset = SET_T;
          4:    oset = SET_D;
          default: begin
            oset = 5'($urandom_range(0, 31));
            if ($countones(oset) == 1) oset = 5'b00011;
          end
        endcase
        applyStimulus(oset, 8'($urandom));
      end
      nBytes  = $urandom_range(1, 8);
      abortAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nBytes - 1) : -1;
      aborted = 1'b0;
      applyStimulus(SET_S, 8'($urandom));
      for (int b = 0; b < nBytes; b++) begin
        if (b == abortAt) begin
          applyReset();
          aborted = 1'b1;
          break;
        end
        applyStimulus(SET_D, 8'($urandom));
      end
      if (!aborted) begin
        applyStimulus(SET_T, 8'($urandom));
        applyStimulus(SET_R, 8'($urandom));
      end
    end
    repeat (6) applyStimulus(SET_I, 8'h00);
    @(negedge clock);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
